// File: rtl/db15_pkg.sv
// db15_pkg: shared types and constants for the DB15 serial joystick scanner.
package db15_pkg;
  localparam int FRAME_BITS = 32;
  localparam int PLAYER_BITS = 16;
  localparam int USED_BITS = 12;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  function automatic logic [PLAYER_BITS-1:0] decode_player(input logic [USED_BITS-1:0] r);
    return {{(PLAYER_BITS-USED_BITS){1'b0}}, ~r};
  endfunction
endpackage

// File: rtl/db15_sync.sv
// db15_sync: two-flop synchroniser with a selectable reset value.
module db15_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (reset) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/db15_serial_joy.sv
// db15_serial_joy: scans a 32-bit DB15 adapter shift chain and publishes two player button words.
module db15_serial_joy
  import db15_pkg::*;
#(
  parameter int CLK_DIV = 24,
  parameter int GAP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        joy_clk,
  output logic        joy_load,
  input  logic        joy_data,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done,
  output logic        present
);
  localparam int CNT_MAX = GAP_CYCLES > 2 * CLK_DIV ? GAP_CYCLES : 2 * CLK_DIV;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_BITS - 1);
  state_t state, next;
  logic [CW-1:0] cnt, cnt_next, phase_last;
  logic [IW-1:0] idx, idx_next;
  logic [FRAME_BITS-1:0] raw;
  logic data_s, phase_end, sample, latch, stuck;
  db15_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (joy_data),
    .q    (data_s)
  );
  always_comb begin
    phase_last = state == IDLE ? GAP_LAST : state == LOAD ? LOAD_LAST : DIV_LAST;
    phase_end = state == LATCH || cnt == phase_last;
    next = !phase_end ? state :
           state == IDLE ? LOAD :
           state == LOAD ? SHIFT_LO :
           state == SHIFT_LO ? SHIFT_HI :
           state == SHIFT_HI ? (idx == LAST_BIT ? LATCH : SHIFT_LO) : IDLE;
    cnt_next = phase_end ? '0 : cnt + 1'b1;
    idx_next = state == LOAD ? '0 :
               (state == SHIFT_HI && phase_end && idx != LAST_BIT) ? idx + 1'b1 : idx;
    sample = state == SHIFT_LO && phase_end;
    latch = state == LATCH;
    stuck = ~|raw;
  end
  // Pin outputs are registered from the next state so they are glitch-free yet phase-aligned with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      raw <= '0;
      joy_clk <= 1'b1;
      joy_load <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      frame_done <= 1'b0;
      present <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_next;
      idx <= idx_next;
      if (sample) raw[idx] <= data_s;
      joy_clk <= next != SHIFT_LO;
      joy_load <= next != LOAD;
      frame_done <= latch;
      if (latch) begin
        present <= !stuck;
        joystick1 <= stuck ? '0 : decode_player(raw[USED_BITS-1:0]);
        joystick2 <= stuck ? '0 : decode_player(raw[PLAYER_BITS+USED_BITS-1:PLAYER_BITS]);
      end
    end
  end
endmodule

// File: tb/tb_db15_serial_joy.sv
// tb_db15_serial_joy: randomized scenario bench with a behavioural adapter and button-level reference model.
module tb_db15_serial_joy;
  localparam int CLK_DIV = 4;
  localparam int GAP = 8;
  localparam int FRAME = GAP + 2 * CLK_DIV + 64 * CLK_DIV + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic joy_data, joy_clk, joy_load, frame_done, present;
  logic [15:0] joystick1, joystick2;
  int total = 0;
  int bad = 0;
  logic [31:0] pat = '1;
  logic stuck = 1'b0;
  logic win = 1'b0;
  int idx = 0;
  int lo_cnt = 0;
  logic prev_jc = 1'b1;
  logic bit_val;

  always #5 clk = ~clk;

  db15_serial_joy #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .joy_clk   (joy_clk),
    .joy_load  (joy_load),
    .joy_data  (joy_data),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .frame_done(frame_done),
    .present   (present)
  );

  // Adapter: parallel load while joy_load is low, advance one bit per joy_clk rising edge.
  always @(posedge clk) begin
    prev_jc <= joy_clk;
    if (!joy_load) idx <= 0;
    else if (joy_clk && !prev_jc) idx <= idx + 1;
    lo_cnt <= joy_clk ? 0 : lo_cnt + 1;
  end
  assign bit_val = (idx >= 0 && idx < 32) ? pat[idx[4:0]] : 1'b1;
  // Window mode shows the true bit only in the 2nd low cycle, the one a correctly timed sample sees.
  assign joy_data = stuck ? 1'b0 : win ? ((lo_cnt == 1) ? bit_val : ~bit_val) : bit_val;

  function automatic logic [15:0] exp_joy(input logic [31:0] p, input int pl);
    logic [15:0] r;
    r = '0;
    if (p == 0) return r;
    for (int i = 0; i < 12; i++) r[i] = !p[pl * 16 + i];
    return r;
  endfunction

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 2 * FRAME);
    if (!frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 6;
    if (joy_clk !== 1'b1) begin bad++; $display("FAIL rst_joy_clk got=%b exp=1", joy_clk); end
    if (joy_load !== 1'b1) begin bad++; $display("FAIL rst_joy_load got=%b exp=1", joy_load); end
    if (joystick1 !== 16'h0) begin bad++; $display("FAIL rst_joystick1 got=%h exp=0000", joystick1); end
    if (joystick2 !== 16'h0) begin bad++; $display("FAIL rst_joystick2 got=%h exp=0000", joystick2); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    if (present !== 1'b0) begin bad++; $display("FAIL rst_present got=%b exp=0", present); end
  endtask

  task automatic test_waveform();
    logic jl [0:FRAME];
    logic jc [0:FRAME];
    logic fd [0:FRAME];
    int first_low, load_len, load_clk_low, pair_err, falls, fd_cnt, fd_at;
    pat = $urandom;
    if (pat == 0) pat = 32'h1;
    win = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      jl[k] = joy_load;
      jc[k] = joy_clk;
      fd[k] = frame_done;
    end
    first_low = -1;
    for (int k = 1; k <= FRAME; k++) if (!jl[k] && first_low < 0) first_low = k;
    load_len = 0;
    if (first_low > 0) for (int k = first_low; k <= FRAME && !jl[k]; k++) load_len++;
    load_clk_low = 0;
    for (int k = GAP; k < GAP + 2 * CLK_DIV; k++) if (!jc[k]) load_clk_low++;
    pair_err = 0;
    for (int p = 0; p < 32; p++)
      for (int j = 0; j < 2 * CLK_DIV; j++) begin
        int k = GAP + 2 * CLK_DIV + 2 * CLK_DIV * p + j;
        if (jc[k] !== (j >= CLK_DIV) || jl[k] !== 1'b1) pair_err++;
      end
    falls = 0;
    for (int k = 2; k <= FRAME; k++) if (jc[k-1] && !jc[k]) falls++;
    fd_cnt = 0;
    fd_at = -1;
    for (int k = 1; k <= FRAME; k++) if (fd[k]) begin fd_cnt++; if (fd_at < 0) fd_at = k; end
    total += 9;
    if (first_low !== GAP) begin bad++; $display("FAIL wave_first_load got=%0d exp=%0d", first_low, GAP); end
    if (load_len !== 2 * CLK_DIV) begin bad++; $display("FAIL wave_load_len got=%0d exp=%0d", load_len, 2 * CLK_DIV); end
    if (load_clk_low !== 0) begin bad++; $display("FAIL wave_clk_in_load got=%0d exp=0", load_clk_low); end
    if (pair_err !== 0) begin bad++; $display("FAIL wave_clk_pairs got=%0d exp=0", pair_err); end
    if (falls !== 32) begin bad++; $display("FAIL wave_clk_falls got=%0d exp=32", falls); end
    if (fd_at !== FRAME || fd_cnt !== 1) begin bad++; $display("FAIL wave_frame_done got_at=%0d cnt=%0d exp_at=%0d", fd_at, fd_cnt, FRAME); end
    if (joystick1 !== exp_joy(pat, 0)) begin bad++; $display("FAIL wave_sample_p1 got=%h exp=%h", joystick1, exp_joy(pat, 0)); end
    if (joystick2 !== exp_joy(pat, 1)) begin bad++; $display("FAIL wave_sample_p2 got=%h exp=%h", joystick2, exp_joy(pat, 1)); end
    if (present !== 1'b1) begin bad++; $display("FAIL wave_present got=%b exp=1", present); end
    win = 1'b0;
  endtask

  task automatic test_idle_pads();
    int c;
    pat = '1;
    for (int f = 0; f < 2; f++) begin
      wait_frame(c);
      total += 4;
      if (c !== FRAME) begin bad++; $display("FAIL idle_period got=%0d exp=%0d", c, FRAME); end
      if (joystick1 !== 16'h0) begin bad++; $display("FAIL idle_p1 got=%h exp=0000", joystick1); end
      if (joystick2 !== 16'h0) begin bad++; $display("FAIL idle_p2 got=%h exp=0000", joystick2); end
      if (present !== 1'b1) begin bad++; $display("FAIL idle_present got=%b exp=1", present); end
    end
  endtask

  task automatic test_single_buttons();
    int c;
    pat = '1;
    pat[0] = 1'b0;
    pat[20] = 1'b0;
    wait_frame(c);
    total += 2;
    if (joystick1 !== 16'h0001) begin bad++; $display("FAIL single_p1 got=%h exp=0001", joystick1); end
    if (joystick2 !== 16'h0010) begin bad++; $display("FAIL single_p2 got=%h exp=0010", joystick2); end
  endtask

  task automatic test_upper_ignored();
    int c;
    pat = 32'h0FFF_0FFF;
    wait_frame(c);
    total += 3;
    if (joystick1 !== 16'h0) begin bad++; $display("FAIL upper_p1 got=%h exp=0000", joystick1); end
    if (joystick2 !== 16'h0) begin bad++; $display("FAIL upper_p2 got=%h exp=0000", joystick2); end
    if (present !== 1'b1) begin bad++; $display("FAIL upper_present got=%b exp=1", present); end
  endtask

  task automatic test_stuck_low();
    int c;
    stuck = 1'b1;
    wait_frame(c);
    total += 3;
    if (joystick1 !== 16'h0) begin bad++; $display("FAIL stuck_p1 got=%h exp=0000", joystick1); end
    if (joystick2 !== 16'h0) begin bad++; $display("FAIL stuck_p2 got=%h exp=0000", joystick2); end
    if (present !== 1'b0) begin bad++; $display("FAIL stuck_present got=%b exp=0", present); end
    stuck = 1'b0;
    pat = 32'hFFFE_FFFD;
    wait_frame(c);
    total += 3;
    if (present !== 1'b1) begin bad++; $display("FAIL unstuck_present got=%b exp=1", present); end
    if (joystick1 !== exp_joy(pat, 0)) begin bad++; $display("FAIL unstuck_p1 got=%h exp=%h", joystick1, exp_joy(pat, 0)); end
    if (joystick2 !== exp_joy(pat, 1)) begin bad++; $display("FAIL unstuck_p2 got=%h exp=%h", joystick2, exp_joy(pat, 1)); end
  endtask

  task automatic test_random();
    int cyc, changed;
    logic [15:0] o1, o2;
    logic op;
    for (int f = 0; f < 8; f++) begin
      pat = $urandom;
      o1 = joystick1;
      o2 = joystick2;
      op = present;
      cyc = 0;
      changed = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!frame_done && (joystick1 !== o1 || joystick2 !== o2 || present !== op)) changed++;
      end while (!frame_done && cyc < 2 * FRAME);
      total += 4;
      if (!frame_done || changed !== 0) begin bad++; $display("FAIL rand_stable frame=%0d changes=%0d done=%b exp_changes=0", f, changed, frame_done); end
      if (joystick1 !== exp_joy(pat, 0)) begin bad++; $display("FAIL rand_p1 pat=%h got=%h exp=%h", pat, joystick1, exp_joy(pat, 0)); end
      if (joystick2 !== exp_joy(pat, 1)) begin bad++; $display("FAIL rand_p2 pat=%h got=%h exp=%h", pat, joystick2, exp_joy(pat, 1)); end
      if (present !== (pat != 0)) begin bad++; $display("FAIL rand_present pat=%h got=%b exp=%b", pat, present, pat != 0); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int c, falls, k;
    logic prev;
    pat = '1;
    pat[0] = 1'b0;
    wait_frame(c);
    total++;
    if (joystick1 !== 16'h0001) begin bad++; $display("FAIL mid_pre_p1 got=%h exp=0001", joystick1); end
    c = 0;
    while (joy_load && c < 2 * FRAME) begin @(negedge clk); c++; end
    falls = 0;
    prev = joy_clk;
    while (falls < 11 && c < 4 * FRAME) begin
      @(negedge clk);
      c++;
      if (prev && !joy_clk) falls++;
      prev = joy_clk;
    end
    total++;
    if (falls !== 11) begin bad++; $display("FAIL mid_reach_bit10 got=%0d exp=11", falls); end
    reset = 1'b1;
    @(negedge clk);
    total += 5;
    if (joystick1 !== 16'h0) begin bad++; $display("FAIL mid_p1 got=%h exp=0000", joystick1); end
    if (joy_clk !== 1'b1) begin bad++; $display("FAIL mid_joy_clk got=%b exp=1", joy_clk); end
    if (joy_load !== 1'b1) begin bad++; $display("FAIL mid_joy_load got=%b exp=1", joy_load); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_frame_done got=%b exp=0", frame_done); end
    if (present !== 1'b0) begin bad++; $display("FAIL mid_present got=%b exp=0", present); end
    reset = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (joy_load && k < 50);
    total++;
    if (k !== GAP) begin bad++; $display("FAIL mid_first_load got=%0d exp=%0d", k, GAP); end
    wait_frame(c);
    total += 2;
    if (joystick1 !== 16'h0001) begin bad++; $display("FAIL mid_recover_p1 got=%h exp=0001", joystick1); end
    if (present !== 1'b1) begin bad++; $display("FAIL mid_recover_present got=%b exp=1", present); end
  endtask

  task automatic test_pulse_width();
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", frame_done); end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_idle_pads();
    test_single_buttons();
    test_upper_ignored();
    test_stuck_low();
    test_random();
    test_reset_mid_scan();
    test_pulse_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
